// File: rtl/instruction_fetch_unit.sv
// Program store and sequencer feeding the 4-bit CPU's 9-bit Instruction input.
// Optional single-step gating is enabled with `define IFU_SINGLE_STEP_EN.
module instruction_fetch_unit #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int IW    = 9
) (
    input  logic          CLK,
    input  logic          Reset,
    input  logic          load_en,
    input  logic [AW-1:0] load_addr,
    input  logic [IW-1:0] load_data,
    input  logic          start,
`ifdef IFU_SINGLE_STEP_EN
    input  logic          step,
`endif
    output logic [IW-1:0] Instruction,
    output logic          instr_valid,
    output logic [AW-1:0] pc,
    output logic          busy,
    output logic          halted
);

    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

    state_t        state_reg, state_next;
    logic [AW-1:0] pc_reg, pc_next;
    logic [IW-1:0] instr_reg, instr_next;
    logic          valid_reg, valid_next;
    logic          last_reg, last_next;
    logic [IW-1:0] mem [DEPTH];
    logic [IW-1:0] word;
    logic          fetch;
    logic          mem_we;
    logic          is_halt;

    assign word    = mem[pc_reg];
    assign is_halt = (word[IW-1 -: 3] == 3'b111);
    assign mem_we  = load_en && (state_reg != RUN);
`ifdef IFU_SINGLE_STEP_EN
    assign fetch   = (state_reg == RUN) && step;
`else
    assign fetch   = (state_reg == RUN);
`endif

    // Memory is cleared by reset, so it is kept in registers rather than block RAM.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (mem_we) begin
            mem[load_addr] <= load_data;
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_reg <= IDLE;
            pc_reg    <= '0;
            instr_reg <= '0;
            valid_reg <= 1'b0;
            last_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            instr_reg <= instr_next;
            valid_reg <= valid_next;
            last_reg  <= last_next;
        end
    end

    // Instruction defaults to the bubble so any non-issue cycle is harmless to the CPU.
    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        instr_next = '0;
        valid_next = 1'b0;
        last_next  = last_reg;
        case (state_reg)
            IDLE, HALT: begin
                if (start && !load_en) begin
                    state_next = RUN;
                    pc_next    = '0;
                    last_next  = 1'b0;
                end
            end
            RUN: begin
                if (fetch) begin
                    if (last_reg || is_halt) begin
                        state_next = HALT;
                    end else begin
                        instr_next = word;
                        valid_next = 1'b1;
                        // The final word pins pc at the top; last_reg ends the run next fetch.
                        if (pc_reg == AW'(DEPTH - 1)) begin
                            last_next = 1'b1;
                        end else begin
                            pc_next = pc_reg + 1'b1;
                        end
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign Instruction = instr_reg;
    assign instr_valid = valid_reg;
    assign pc          = pc_reg;
    assign busy        = (state_reg == RUN);
    assign halted      = (state_reg == HALT);

endmodule
